noise_envelope: RTL and testbench
=================================

NOISE_ENVELOPE -- requirements
Module: noise_envelope

Interface
REQ-001 SHALL have parameter ACC_W, default 16, envelope accumulator width; only 16 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port sample_tick, input, 1, one-cycle sample-rate strobe.
REQ-005 SHALL have port gate, input, 1, note on (1) / note off (0), level-sensitive.
REQ-006 SHALL have port noise_in, input, 16, signed noise word from the upstream LFSR stage.
REQ-007 SHALL have port attack_rate, input, 8, unsigned attack step control.
REQ-008 SHALL have port decay_rate, input, 8, unsigned decay step control.
REQ-009 SHALL have port sustain_level, input, 8, unsigned sustain target.
REQ-010 SHALL have port release_rate, input, 8, unsigned release step control.
REQ-011 SHALL have port lfsr_enable, output, 1, advance strobe to the upstream LFSR enable.
REQ-012 SHALL have port sample_out, output, 16, signed enveloped noise sample.
REQ-013 SHALL have port sample_valid, output, 1, one-cycle qualifier for sample_out.
REQ-014 SHALL have port env_state, output, 3, current FSM state encoding.

Function
REQ-015 SHALL drive lfsr_enable combinationally equal to sample_tick.
REQ-016 SHALL implement FSM states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, with state and env (16-bit unsigned) updating only on cycles with sample_tick=1.
REQ-017 SHALL use step = {4'b0, rate, 4'b0} for the active state's rate; rate 0 holds env and state, except for gate-driven transitions.
REQ-018 SHALL handle ATTACK as: if env+step >= 0xFFFF (17-bit compare), env=0xFFFF and go to DECAY; else env += step.
REQ-019 SHALL handle DECAY with target = {sustain_level, 8'h00} as: if env-step <= target (signed 17-bit, no wrap), env=target and go to SUSTAIN; else env -= step.
REQ-020 SHALL hold env in SUSTAIN; a sustain_level change there SHALL NOT move env.
REQ-021 SHALL handle RELEASE as: if env <= step, env=0 and go to IDLE; else env -= step.
REQ-022 SHALL, on a tick with gate=0 in ATTACK, DECAY or SUSTAIN, go to RELEASE without applying that tick's step.
REQ-023 SHALL, on a tick with gate=1 in IDLE or RELEASE, go to ATTACK, keeping env (no reset to 0).
REQ-024 SHALL give gate transitions priority over threshold transitions on the same tick.
REQ-025 SHALL register noise_in one cycle after the tick (T+1).
REQ-026 SHALL, at T+2, register sample_out = bits [23:8] of signed(noise_in) * unsigned(env[15:8]) (24-bit product, arithmetic floor) and pulse sample_valid for exactly one cycle.
REQ-027 SHALL, when ticks arrive on consecutive cycles, produce one valid sample per tick in order (fully pipelined).

Reset
REQ-028 SHALL, on reset, asynchronously clear state to IDLE, env to 0, sample_out to 0, sample_valid to 0 and the pipeline registers to 0; lfsr_enable follows sample_tick even during reset.
REQ-029 SHALL discard any in-flight sample when reset is asserted mid-pipeline, with no sample_valid after release.

Configuration
REQ-030 SHALL, with NOISE_ENV_EXP_RELEASE_EN defined, use RELEASE step = (env >> 4) + 1 when release_rate != 0, holding when release_rate = 0.
REQ-031 SHALL, without NOISE_ENV_EXP_RELEASE_EN, use the linear RELEASE step of REQ-017/REQ-021.

Structure
REQ-032 SHALL place the state encoding, ACC_W and the step-shift constant (4) in package noise_env_pkg.
REQ-033 SHALL place the REQ-025/026 multiply pipeline in sub-module noise_env_mul; the FSM and env stay in noise_envelope.

Verification
REQ-034 SHALL verify: attack_rate=0xFF, gate=1 from IDLE/env=0 -> env=0xFFFF and DECAY after exactly 17 ticks.
REQ-035 SHALL verify: env=0xFFFF, decay_rate=0x10, sustain_level=0x80 -> env=0x8000 and SUSTAIN after 128 ticks.
REQ-036 SHALL verify: SUSTAIN env=0x8000, gate->0, release_rate=0x80 (linear) -> RELEASE on tick 1, then env=0 and IDLE on tick 17.
REQ-037 SHALL verify: env[15:8]=0xFF, noise_in=0x7FFF -> sample_out=0x7F7F; env[15:8]=0x80, noise_in=0x803F -> sample_out=0xC01F; sample_valid exactly 2 cycles after tick.
REQ-038 SHALL verify: gate re-asserted in RELEASE at env=0x3000 -> ATTACK with env continuing from 0x3000 on the same tick.
REQ-039 SHALL verify: reset asserted between tick and T+2 -> no sample_valid, env_state=0, sample_out=0 immediately.

Source files
------------

// File: rtl/noise_env_pkg.sv
// noise_env_pkg: shared envelope state encoding, accumulator width and rate-to-step scaling
package noise_env_pkg;
    localparam int ACC_W = 16;
    localparam int STEP_SHIFT = 4;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;
    function automatic logic [ACC_W-1:0] rate_step(input logic [7:0] rate);
        return ACC_W'(rate) << STEP_SHIFT;
    endfunction
endpackage

// File: rtl/noise_env_mul.sv
// noise_env_mul: two-stage pipeline scaling signed noise by the unsigned envelope level
module noise_env_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] noise_in,
    input  logic [7:0]  level,
    output logic [15:0] sample_out,
    output logic        sample_valid
);
    logic [15:0] noise_q;
    logic [7:0] level_q;
    logic valid_q;
    logic signed [23:0] prod;
    // |noise * level| < 2^23, so a 24-bit signed product cannot overflow
    assign prod = 24'($signed(noise_q)) * 24'($signed({1'b0, level_q}));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            noise_q <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            sample_out <= '0;
            sample_valid <= 1'b0;
        end else begin
            valid_q <= tick;
            sample_valid <= valid_q;
            if (tick) begin
                noise_q <= noise_in;
                level_q <= level;
            end
            if (valid_q) sample_out <= 16'(prod >>> 8);
        end
    end
endmodule

// File: rtl/noise_envelope.sv
// noise_envelope: ADSR-shaped noise voice; define NOISE_ENV_EXP_RELEASE_EN for an exponential release
module noise_envelope
    import noise_env_pkg::*;
#(
    parameter int ACC_W = noise_env_pkg::ACC_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        gate,
    input  logic [15:0] noise_in,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_rate,
    output logic        lfsr_enable,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [2:0]  env_state
);
    env_state_t state, state_nxt;
    logic [ACC_W-1:0] env, env_nxt, step, rel_step, target;
    logic [ACC_W:0] att_sum, dec_lim;
    logic [7:0] rate;
    assign lfsr_enable = sample_tick;
    assign env_state = state;
    always_comb begin
        rate = state == ATTACK ? attack_rate : state == DECAY ? decay_rate : state == RELEASE ? release_rate : 8'd0;
        step = rate_step(rate);
`ifdef NOISE_ENV_EXP_RELEASE_EN
        rel_step = (env >> STEP_SHIFT) + 1'b1;
`else
        rel_step = step;
`endif
        target = {sustain_level, 8'h00};
        att_sum = {1'b0, env} + {1'b0, step};
        dec_lim = {1'b0, target} + {1'b0, step};
        state_nxt = state;
        env_nxt = env;
        // gate changes win over threshold moves and skip that tick's step
        case (state)
            IDLE: if (gate) state_nxt = ATTACK;
            ATTACK: begin
                if (!gate) state_nxt = RELEASE;
                else if (rate != 8'd0) begin
                    if (att_sum >= {1'b0, {ACC_W{1'b1}}}) begin
                        env_nxt = '1;
                        state_nxt = DECAY;
                    end else env_nxt = att_sum[ACC_W-1:0];
                end
            end
            DECAY: begin
                if (!gate) state_nxt = RELEASE;
                else if (rate != 8'd0) begin
                    if ({1'b0, env} <= dec_lim) begin
                        env_nxt = target;
                        state_nxt = SUSTAIN;
                    end else env_nxt = env - step;
                end
            end
            SUSTAIN: if (!gate) state_nxt = RELEASE;
            RELEASE: begin
                if (gate) state_nxt = ATTACK;
                else if (release_rate != 8'd0) begin
                    if (env <= rel_step) begin
                        env_nxt = '0;
                        state_nxt = IDLE;
                    end else env_nxt = env - rel_step;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            env <= '0;
        end else if (sample_tick) begin
            state <= state_nxt;
            env <= env_nxt;
        end
    end
    noise_env_mul u_mul (
        .clk(clk),
        .reset(reset),
        .tick(sample_tick),
        .noise_in(noise_in),
        .level(env[ACC_W-1:ACC_W-8]),
        .sample_out(sample_out),
        .sample_valid(sample_valid)
    );
endmodule

// File: tb/tb_noise_envelope.sv
// tb_noise_envelope: directed checks of envelope phases, multiply pipeline and reset behaviour
module tb_noise_envelope;
    logic clk = 1'b0, reset = 1'b1, sample_tick = 1'b0, gate = 1'b0;
    logic [15:0] noise_in = 16'h0;
    logic [7:0] attack_rate = 8'h0, decay_rate = 8'h0, sustain_level = 8'h0, release_rate = 8'h0;
    logic lfsr_enable, sample_valid;
    logic [15:0] sample_out;
    logic [2:0] env_state;
    int total = 0, bad = 0;

    noise_envelope #(.ACC_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .sample_tick(sample_tick),
        .gate(gate),
        .noise_in(noise_in),
        .attack_rate(attack_rate),
        .decay_rate(decay_rate),
        .sustain_level(sustain_level),
        .release_rate(release_rate),
        .lfsr_enable(lfsr_enable),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .env_state(env_state)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        sample_tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (env_state !== 3'd0 || dut.env !== 16'h0 || sample_out !== 16'h0 || sample_valid !== 1'b0) begin bad++; $display("FAIL reset_state state=%0d env=%h out=%h valid=%b want 0/0000/0000/0", env_state, dut.env, sample_out, sample_valid); end
        sample_tick = 1'b1;
        #1;
        total++; if (lfsr_enable !== 1'b1) begin bad++; $display("FAIL lfsr_en_hi got=%b want 1", lfsr_enable); end
        sample_tick = 1'b0;
        #1;
        total++; if (lfsr_enable !== 1'b0) begin bad++; $display("FAIL lfsr_en_lo got=%b want 0", lfsr_enable); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_attack;
        gate = 1'b1;
        attack_rate = 8'hFF;
        ticks(1);
        total++; if (env_state !== 3'd1 || dut.env !== 16'h0000) begin bad++; $display("FAIL attack_enter state=%0d env=%h want 1/0000", env_state, dut.env); end
        ticks(16);
        total++; if (env_state !== 3'd1 || dut.env !== 16'hFF00) begin bad++; $display("FAIL attack_16 state=%0d env=%h want 1/ff00", env_state, dut.env); end
        ticks(1);
        total++; if (env_state !== 3'd2 || dut.env !== 16'hFFFF) begin bad++; $display("FAIL attack_17 state=%0d env=%h want 2/ffff", env_state, dut.env); end
    endtask

    task automatic test_multiply(input logic [15:0] n, input logic [15:0] want);
        repeat (3) @(posedge clk);
        #1;
        noise_in = n;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        noise_in = 16'h1234;
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL mul_t1_valid got=%b want 0", sample_valid); end
        @(posedge clk);
        #1;
        total++; if (sample_valid !== 1'b1 || sample_out !== want) begin bad++; $display("FAIL mul_t2 valid=%b out=%h want 1/%h", sample_valid, sample_out, want); end
        @(posedge clk);
        #1;
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL mul_t3_valid got=%b want 0", sample_valid); end
    endtask

    task automatic test_decay;
        decay_rate = 8'h10;
        sustain_level = 8'h80;
        ticks(127);
        total++; if (env_state !== 3'd2 || dut.env !== 16'h80FF) begin bad++; $display("FAIL decay_127 state=%0d env=%h want 2/80ff", env_state, dut.env); end
        ticks(1);
        total++; if (env_state !== 3'd3 || dut.env !== 16'h8000) begin bad++; $display("FAIL decay_128 state=%0d env=%h want 3/8000", env_state, dut.env); end
        sustain_level = 8'h40;
        ticks(1);
        total++; if (env_state !== 3'd3 || dut.env !== 16'h8000) begin bad++; $display("FAIL sustain_hold state=%0d env=%h want 3/8000", env_state, dut.env); end
        sustain_level = 8'h80;
    endtask

    task automatic test_release;
        gate = 1'b0;
        release_rate = 8'h80;
        ticks(1);
        total++; if (env_state !== 3'd4 || dut.env !== 16'h8000) begin bad++; $display("FAIL release_1 state=%0d env=%h want 4/8000", env_state, dut.env); end
        ticks(15);
        total++; if (env_state !== 3'd4 || dut.env !== 16'h0800) begin bad++; $display("FAIL release_16 state=%0d env=%h want 4/0800", env_state, dut.env); end
        ticks(1);
        total++; if (env_state !== 3'd0 || dut.env !== 16'h0000) begin bad++; $display("FAIL release_17 state=%0d env=%h want 0/0000", env_state, dut.env); end
        ticks(1);
        total++; if (env_state !== 3'd0 || dut.env !== 16'h0000) begin bad++; $display("FAIL idle_hold state=%0d env=%h want 0/0000", env_state, dut.env); end
    endtask

    task automatic test_retrigger;
        attack_rate = 8'h30;
        gate = 1'b1;
        ticks(17);
        total++; if (env_state !== 3'd1 || dut.env !== 16'h3000) begin bad++; $display("FAIL retrig_attack state=%0d env=%h want 1/3000", env_state, dut.env); end
        gate = 1'b0;
        ticks(1);
        total++; if (env_state !== 3'd4 || dut.env !== 16'h3000) begin bad++; $display("FAIL retrig_release state=%0d env=%h want 4/3000", env_state, dut.env); end
        release_rate = 8'h00;
        ticks(1);
        total++; if (env_state !== 3'd4 || dut.env !== 16'h3000) begin bad++; $display("FAIL release_rate0 state=%0d env=%h want 4/3000", env_state, dut.env); end
        gate = 1'b1;
        ticks(1);
        total++; if (env_state !== 3'd1 || dut.env !== 16'h3000) begin bad++; $display("FAIL retrig_gate state=%0d env=%h want 1/3000", env_state, dut.env); end
        ticks(1);
        total++; if (env_state !== 3'd1 || dut.env !== 16'h3300) begin bad++; $display("FAIL retrig_step state=%0d env=%h want 1/3300", env_state, dut.env); end
        attack_rate = 8'h00;
        ticks(1);
        total++; if (env_state !== 3'd1 || dut.env !== 16'h3300) begin bad++; $display("FAIL attack_rate0 state=%0d env=%h want 1/3300", env_state, dut.env); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vec [4];
        logic [15:0] want [4];
        logic exp_v;
        vec = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFFFF};
        want = '{16'h197F, 16'hE680, 16'h0033, 16'hFFFF};
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 7; c++) begin
            exp_v = (c >= 2 && c <= 5);
            total++; if (sample_valid !== exp_v) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want %b", c, sample_valid, exp_v); end
            if (exp_v) begin
                total++; if (sample_out !== want[c-2]) begin bad++; $display("FAIL b2b_sample c=%0d got=%h want %h", c, sample_out, want[c-2]); end
            end
            sample_tick = (c < 4);
            noise_in = (c < 4) ? vec[c] : 16'h0;
            @(posedge clk);
            #1;
        end
        sample_tick = 1'b0;
    endtask

    task automatic test_reset_midpipe;
        repeat (3) @(posedge clk);
        #1;
        noise_in = 16'h7FFF;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++; if (env_state !== 3'd0 || sample_out !== 16'h0 || sample_valid !== 1'b0 || dut.env !== 16'h0) begin bad++; $display("FAIL midpipe_reset state=%0d out=%h valid=%b env=%h want 0/0000/0/0000", env_state, sample_out, sample_valid, dut.env); end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL midpipe_valid c=%0d got=%b want 0", c, sample_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_attack;
        test_multiply(16'h7FFF, 16'h7F7F);
        test_decay;
        test_multiply(16'h803F, 16'hC01F);
        test_release;
        test_retrigger;
        test_back_to_back;
        test_reset_midpipe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
